// File: rtl/mmu_paged_ctl.sv
// rtl/mmu_paged_ctl.sv - 6809 paged MMU: Q/E clock generator, on-chip task page map, write protect, fault latch, RTI return
module mmu_paged_ctl #(
  parameter logic [15:0] IO_PAGE    = 16'hFE00,
  parameter int          TASK_BITS  = 5,
  parameter int          PAGE_BITS  = 3,
  parameter int          PHYS_BITS  = 6,
  parameter int          PROTECT_HW = 0,
  parameter int          RTI_DELAY  = 1
) (
  input  logic                 CLKX4,
  input  logic                 nRESET,
  input  logic                 MRDY,
  output logic                 QX,
  output logic                 EX,
  input  logic [15:0]          ADDR,
  input  logic                 RnW,
  input  logic                 BA,
  input  logic                 BS,
  input  logic [7:0]           DATA_in,
  output logic [7:0]           DATA_out,
  output logic                 DATA_oe,
  output logic [PHYS_BITS-1:0] PPN,
  output logic                 nCSIO,
  output logic                 nRD,
  output logic                 nWR,
  output logic                 nIRQ_MMU
);

  localparam int          NPAGES   = 1 << PAGE_BITS;
  localparam int          NTASKS   = 1 << TASK_BITS;
  localparam int          IDX_BITS = TASK_BITS + PAGE_BITS;
  localparam logic [7:0]  MAP_BASE = 8'h20;
  localparam logic [2:0]  ARM_LOAD = 3'(RTI_DELAY + 1);

  // Phase encoding is {QX,EX}, so the outputs come straight from the state flops.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  phase_t phase;

  logic                 enmmu;
  logic                 s_mode;
  logic [TASK_BITS-1:0] access_key;
  logic [TASK_BITS-1:0] task_key;
  logic                 fault_valid;
  logic [TASK_BITS-1:0] fault_task;
  logic [PAGE_BITS-1:0] fault_page;
  logic [2:0]           arm_cnt;

  logic [PHYS_BITS:0]   map_mem [NTASKS*NPAGES];

  logic                 commit;
  logic [PAGE_BITS-1:0] page;
  logic                 vec;
  logic [TASK_BITS-1:0] cur_task;
  logic [IDX_BITS-1:0]  xlat_idx;
  logic [IDX_BITS-1:0]  win_idx;
  logic [PHYS_BITS:0]   xlat_entry;
  logic [PHYS_BITS:0]   win_entry;
  logic                 protect_mask;
  logic                 io_raw;
  logic                 io_hit;
  logic                 reg_hit;
  logic                 map_hit;
  logic                 wp_block;
  logic                 map_wr;
  logic                 reg_wr;
  logic                 rti_rd;
  logic                 fstat_rd;
  logic                 fault_set;
  logic [7:0]           reg_rd;
  logic [7:0]           map_rd;
  logic                 unused_data;

  assign QX     = phase[1];
  assign EX     = phase[0];
  assign commit = (phase == PH_01) & MRDY;

  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      phase <= PH_00;
    end else begin
      case (phase)
        PH_00:   phase <= PH_10;
        PH_10:   phase <= PH_11;
        PH_11:   phase <= PH_01;
        PH_01:   phase <= MRDY ? PH_00 : PH_01;
        default: phase <= PH_00;
      endcase
    end
  end

  assign page       = ADDR[15 -: PAGE_BITS];
  assign vec        = !BA & BS & RnW;
  assign cur_task   = (s_mode | vec) ? '0 : task_key;
  assign xlat_idx   = {cur_task, page};
  assign win_idx    = {access_key, ADDR[PAGE_BITS-1:0]};
  assign xlat_entry = map_mem[xlat_idx];
  assign win_entry  = map_mem[win_idx];

  // With hardware protection, user code sees the I/O page as plain memory.
  assign protect_mask = (PROTECT_HW != 0) & !s_mode & enmmu;
  assign io_raw       = (ADDR[15:8] == IO_PAGE[15:8]);
  assign io_hit       = io_raw & !protect_mask;
  assign reg_hit      = io_hit & (ADDR[7:3] == 5'b00010);
  assign map_hit      = io_hit & (ADDR[7:PAGE_BITS] == MAP_BASE[7:PAGE_BITS]);

  assign wp_block = enmmu & !s_mode & !RnW & xlat_entry[PHYS_BITS] & !io_hit;

  assign PPN      = enmmu ? xlat_entry[PHYS_BITS-1:0] : PHYS_BITS'(page);
  assign nRD      = !(EX & RnW);
  assign nWR      = !(EX & !RnW & !wp_block);
  assign nCSIO    = !(EX & io_hit & !reg_hit & !map_hit);
  assign DATA_oe  = EX & RnW & (reg_hit | map_hit);
  assign nIRQ_MMU = !fault_valid;

  assign map_wr    = commit & !RnW & map_hit;
  assign reg_wr    = commit & !RnW & reg_hit;
  assign rti_rd    = commit & RnW & reg_hit & (ADDR[2:0] == 3'd3);
  assign fstat_rd  = commit & RnW & reg_hit & (ADDR[2:0] == 3'd4);
  assign fault_set = commit & wp_block;

  always_comb begin
    reg_rd = 8'h00;
    case (ADDR[2:0])
      3'd0:    reg_rd = {6'b0, s_mode, enmmu};
      3'd1:    reg_rd = 8'(access_key);
      3'd2:    reg_rd = 8'(task_key);
      3'd3:    reg_rd = 8'h3B;
      3'd4:    reg_rd = {fault_valid, 2'b0, 5'(fault_task)};
      3'd5:    reg_rd = {4'b0, 4'(fault_page)};
      default: reg_rd = 8'h00;
    endcase
  end

  always_comb begin
    map_rd                  = 8'h00;
    map_rd[7]               = win_entry[PHYS_BITS];
    map_rd[PHYS_BITS-1:0]   = win_entry[PHYS_BITS-1:0];
  end

  assign DATA_out    = reg_hit ? reg_rd : map_rd;
  assign unused_data = ^DATA_in;

  // Map RAM has no reset; software initialises it before enabling the MMU.
  always_ff @(posedge CLKX4) begin
    if (map_wr) begin
      map_mem[win_idx] <= {DATA_in[7], DATA_in[PHYS_BITS-1:0]};
    end
  end

  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      enmmu       <= 1'b0;
      s_mode      <= 1'b1;
      access_key  <= '0;
      task_key    <= '0;
      fault_valid <= 1'b0;
      fault_task  <= '0;
      fault_page  <= '0;
      arm_cnt     <= 3'd0;
    end else begin
      if (reg_wr) begin
        case (ADDR[2:0])
          3'd0:    enmmu      <= DATA_in[0];
          3'd1:    access_key <= DATA_in[TASK_BITS-1:0];
          3'd2:    task_key   <= DATA_in[TASK_BITS-1:0];
          default: ;
        endcase
      end

      // The first fault is kept until software reads FSTAT.
      if (fault_set && (!fault_valid || fstat_rd)) begin
        fault_valid <= 1'b1;
        fault_task  <= task_key;
        fault_page  <= page;
      end else if (fstat_rd) begin
        fault_valid <= 1'b0;
      end

      if (commit) begin
        if (vec) begin
          s_mode  <= 1'b1;
          arm_cnt <= 3'd0;
        end else if (rti_rd) begin
          arm_cnt <= ARM_LOAD;
        end else if (arm_cnt != 3'd0) begin
          arm_cnt <= arm_cnt - 3'd1;
          if (arm_cnt == 3'd1) begin
            s_mode <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mmu_paged_ctl.sv
// tb/tb_mmu_paged_ctl.sv - self-checking bench for mmu_paged_ctl against a transaction-level model
module tb_mmu_paged_ctl;

  localparam int RTI_DELAY = 1;

  logic        CLKX4 = 1'b0;
  logic        nRESET;
  logic        MRDY;
  logic        QX, EX;
  logic [15:0] ADDR;
  logic        RnW, BA, BS;
  logic [7:0]  DATA_in;
  logic [7:0]  DATA_out;
  logic        DATA_oe;
  logic [5:0]  PPN;
  logic        nCSIO, nRD, nWR, nIRQ_MMU;

  mmu_paged_ctl #(
    .IO_PAGE(16'hFE00), .TASK_BITS(5), .PAGE_BITS(3), .PHYS_BITS(6),
    .PROTECT_HW(0), .RTI_DELAY(RTI_DELAY)
  ) dut (
    .CLKX4(CLKX4), .nRESET(nRESET), .MRDY(MRDY), .QX(QX), .EX(EX),
    .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS), .DATA_in(DATA_in),
    .DATA_out(DATA_out), .DATA_oe(DATA_oe), .PPN(PPN), .nCSIO(nCSIO),
    .nRD(nRD), .nWR(nWR), .nIRQ_MMU(nIRQ_MMU)
  );

  always #5 CLKX4 = ~CLKX4;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: architectural state only, updated once per bus cycle.
  bit m_en, m_s, m_fvalid;
  int m_akey, m_tkey, m_ftask, m_fpage, m_arm;
  bit m_wp   [32][8];
  int m_phys [32][8];

  logic [7:0] cap_rd;
  logic [5:0] cap_ppn;
  logic       cap_nwr, cap_ncsio, cap_oe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_s = 1; m_fvalid = 0;
    m_akey = 0; m_tkey = 0; m_ftask = 0; m_fpage = 0; m_arm = 0;
  endtask

  task automatic bus(input logic [15:0] a, input bit rnw, input logic [7:0] d, input bit vec_fetch);
    int  guard = 0;
    int  page  = int'(a[15:13]);
    bit  vec   = vec_fetch && rnw;
    int  tsk   = (m_s || vec) ? 0 : m_tkey;
    bit  io    = (a[15:8] == 8'hFE);
    int  off   = int'(a[7:0]);
    bit  rg    = io && off >= 16 && off < 24;
    bit  mp    = io && off >= 32 && off < 40;
    bit  wpb   = m_en && !m_s && !rnw && m_wp[tsk][page] && !io;
    int  e_ppn = m_en ? m_phys[tsk][page] : page;
    int  e_rd  = 0;
    if (rg) begin
      case (off - 16)
        0: e_rd = (int'(m_s) << 1) | int'(m_en);
        1: e_rd = m_akey;
        2: e_rd = m_tkey;
        3: e_rd = 8'h3B;
        4: e_rd = (int'(m_fvalid) << 7) | m_ftask;
        5: e_rd = m_fpage;
        default: e_rd = 0;
      endcase
    end else if (mp) begin
      e_rd = (int'(m_wp[m_akey][off-32]) << 7) | m_phys[m_akey][off-32];
    end

    while ({QX, EX} != 2'b00 && guard < 8) begin
      @(posedge CLKX4); #1; guard++;
    end
    chk("bus_start_phase", {QX, EX}, 2'b00);
    chk("nirq_level", nIRQ_MMU, !m_fvalid);

    ADDR = a; RnW = rnw; DATA_in = d; BA = 1'b0; BS = vec_fetch;
    @(posedge CLKX4); #1;
    @(posedge CLKX4); #1;
    cap_rd = DATA_out; cap_ppn = PPN; cap_nwr = nWR; cap_ncsio = nCSIO; cap_oe = DATA_oe;
    chk("ex_high", EX, 1'b1);
    chk("ppn", PPN, e_ppn);
    chk("nwr", nWR, !(!rnw && !wpb));
    chk("nrd", nRD, !rnw);
    chk("data_oe", DATA_oe, rnw && (rg || mp));
    chk("ncsio", nCSIO, !(io && !rg && !mp));
    if (rnw && (rg || mp)) chk("data_out", DATA_out, e_rd);
    @(posedge CLKX4); #1;
    @(posedge CLKX4); #1;

    if (!rnw && rg) begin
      if (off == 16) m_en = d[0];
      if (off == 17) m_akey = int'(d[4:0]);
      if (off == 18) m_tkey = int'(d[4:0]);
    end
    if (!rnw && mp) begin
      m_wp[m_akey][off-32]   = d[7];
      m_phys[m_akey][off-32] = int'(d[5:0]);
    end
    if (wpb && !m_fvalid) begin
      m_fvalid = 1; m_ftask = m_tkey; m_fpage = page;
    end else if (rnw && rg && off == 20) begin
      m_fvalid = 0;
    end
    if (vec) begin
      m_s = 1; m_arm = 0;
    end else if (rnw && rg && off == 19) begin
      m_arm = RTI_DELAY + 1;
    end else if (m_arm > 0) begin
      m_arm--;
      if (m_arm == 0) m_s = 0;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b0, d, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    bus(a, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic enter_user();
    wr(16'hFE10, 8'h01);
    rd(16'hFE13);
    rd(16'h0000);
    rd(16'h0000);
  endtask

  task automatic random_cycles(input int n, input bit clear_faults);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      if (a[15:8] == 8'hFE) a[15:8] = 8'h12;
      if (clear_faults && (i % 8) == 7) rd(16'hFE14);
      else bus(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] seq [4];
    logic [7:0] rb;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    nRESET = 1'b0; MRDY = 1'b1; ADDR = 16'h0000; RnW = 1'b1; BA = 1'b0; BS = 1'b0; DATA_in = 8'h00;
    model_reset();

    repeat (3) @(posedge CLKX4);
    #1;
    chk("reset_qe", {QX, EX}, 2'b00);
    chk("reset_nirq", nIRQ_MMU, 1'b1);

    @(negedge CLKX4) nRESET = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLKX4); #1;
      chk("clk_seq", {QX, EX}, seq[(i + 1) % 4]);
    end
    repeat (3) @(posedge CLKX4);
    #1;
    chk("pre_stretch", {QX, EX}, 2'b01);
    MRDY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLKX4); #1;
      chk("stretch_hold", {QX, EX}, 2'b01);
    end
    MRDY = 1'b1;
    @(posedge CLKX4); #1;
    chk("stretch_release", {QX, EX}, 2'b00);

    rd(16'hFE10);
    for (int t = 0; t < 32; t++) begin
      wr(16'hFE11, 8'(t));
      for (int n = 0; n < 8; n++) wr(16'hFE20 + 16'(n), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      wr(16'hFE11, 8'($urandom_range(0, 31)));
      rd(16'hFE20 + 16'($urandom_range(0, 7)));
    end
    rd(16'hFE28);

    wr(16'hFE11, 8'h02);
    wr(16'hFE23, 8'h85);
    rd(16'hFE23);
    rb = cap_rd;
    chk("map_readback_85", rb, 8'h85);
    wr(16'hFE12, 8'h02);
    enter_user();
    rd(16'hFE10);
    chk("ctl_user_mode", cap_rd, 8'h01);
    rd(16'h6123);
    chk("ppn_6123", cap_ppn, 6'd5);

    wr(16'h6000, 8'h55);
    chk("wp_nwr_blocked", cap_nwr, 1'b1);
    rd(16'hFE14);
    chk("fstat_82", cap_rd, 8'h82);
    rd(16'hFE15);
    chk("fpage_03", cap_rd, 8'h03);
    rd(16'h0000);

    random_cycles(48, 1'b1);

    rd(16'hFE13);
    bus(16'hFFFE, 1'b1, 8'h00, 1'b1);
    rd(16'h0000);
    rd(16'h0000);
    rd(16'h0000);
    rd(16'hFE10);
    chk("vec_cancels_arm", cap_rd[1], 1'b1);

    random_cycles(24, 1'b0);

    wr(16'hFE10, 8'h00);
    rd(16'hA000);
    chk("identity_a000", cap_ppn, 6'd5);
    rd(16'hFE40);
    chk("ncsio_fe40", cap_ncsio, 1'b0);
    rd(16'hFE10);
    chk("ncsio_fe10", cap_ncsio, 1'b1);
    chk("oe_fe10", cap_oe, 1'b1);

    wr(16'hFE12, 8'h02);
    enter_user();
    wr(16'h6000, 8'hAA);
    rd(16'hFE13);
    chk("fault_before_reset", nIRQ_MMU, 1'b0);
    ADDR = 16'h0000; RnW = 1'b1; BS = 1'b0;
    @(posedge CLKX4); #1;
    @(posedge CLKX4); #1;
    chk("mid_e_high", EX, 1'b1);
    nRESET = 1'b0;
    #1;
    chk("async_reset_qe", {QX, EX}, 2'b00);
    chk("async_reset_nirq", nIRQ_MMU, 1'b1);
    repeat (2) @(posedge CLKX4);
    #1;
    chk("reset_hold_qe", {QX, EX}, 2'b00);
    @(negedge CLKX4) nRESET = 1'b1;
    model_reset();
    rd(16'hFE10);
    chk("ctl_after_reset", cap_rd, 8'h02);
    rd(16'hFE11);
    rd(16'hFE12);
    rd(16'hFE14);
    chk("fstat_after_reset", cap_rd, 8'h00);
    rd(16'h0000);
    rd(16'h0000);
    rd(16'hFE10);
    chk("s_stays_after_reset", cap_rd, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
